// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX stage and the iterative mult/div unit.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, flush, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one shift-add or
// restoring-subtract step per cycle over a 64-bit working register.
module muldiv_ctrl (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  mdu
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2*W-1:0]  work_q,  work_d;
  logic [W-1:0]    opnd_q,  opnd_d;
  logic [W-1:0]    a_orig_q, a_orig_d;
  logic            is_div_q, is_div_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic            bzero_q, bzero_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Operand conditioning: signs are only meaningful for the signed ops
  logic            sgn_op_c;
  logic            sa_c, sb_c;
  logic [W-1:0]    mag_a_c, mag_b_c;

  assign sgn_op_c = ~mdu.op[0];
  assign sa_c     = sgn_op_c & mdu.a[W-1];
  assign sb_c     = sgn_op_c & mdu.b[W-1];
  assign mag_a_c  = sa_c ? (~mdu.a + W'(1)) : mdu.a;
  assign mag_b_c  = sb_c ? (~mdu.b + W'(1)) : mdu.b;

  // Step datapath: multiply adds into the upper 33 bits, divide trial-subtracts
  logic [W:0]      mul_sum_c;
  logic [W:0]      mul_upper_c;
  logic            div_ge_c;
  logic [W-1:0]    div_diff_c;
  logic [W-1:0]    div_rem_c;
  logic [2*W-1:0]  prod_c;
  logic [W-1:0]    quo_c, rem_c;

  assign mul_sum_c   = {1'b0, work_q[2*W-1:W]} + {1'b0, opnd_q};
  assign mul_upper_c = work_q[0] ? mul_sum_c : {1'b0, work_q[2*W-1:W]};
  assign div_ge_c    = work_q[2*W-1:W-1] >= {1'b0, opnd_q};
  assign div_diff_c  = work_q[2*W-2:W-1] - opnd_q;
  assign div_rem_c   = div_ge_c ? div_diff_c : work_q[2*W-2:W-1];
  assign prod_c      = (neg_a_q ^ neg_b_q) ? (~work_q + (2*W)'(1)) : work_q;
  assign quo_c       = (neg_a_q ^ neg_b_q) ? (~work_q[W-1:0] + W'(1)) : work_q[W-1:0];
  assign rem_c       = neg_a_q ? (~work_q[2*W-1:W] + W'(1)) : work_q[2*W-1:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      a_orig_q <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      a_orig_q <= a_orig_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    a_orig_d = a_orig_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (mdu.mthi) hi_d = mdu.wdata;
        if (mdu.mtlo) lo_d = mdu.wdata;
        if (mdu.start && !mdu.flush) begin
          state_d  = S_RUN;
          count_d  = '0;
          busy_d   = 1'b1;
          is_div_d = mdu.op[1];
          neg_a_d  = sa_c;
          neg_b_d  = sb_c;
          bzero_d  = (mdu.b == '0);
          a_orig_d = mdu.a;
          // Multiply keeps the multiplier in the low half; divide the dividend
          if (mdu.op[1]) begin
            work_d = {{W{1'b0}}, mag_a_c};
            opnd_d = mag_b_c;
          end else begin
            work_d = {{W{1'b0}}, mag_b_c};
            opnd_d = mag_a_c;
          end
        end
      end

      S_RUN: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
          count_d = '0;
          busy_d  = 1'b0;
        end else begin
          if (is_div_q) work_d = {div_rem_c, work_q[W-2:0], div_ge_c};
          else          work_d = {mul_upper_c, work_q[W-1:1]};
          count_d = count_q + CW'(1);
          if (count_q == CW'(31)) begin
            state_d = S_FIX;
            count_d = '0;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!mdu.flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_c[2*W-1:W];
            lo_d = prod_c[W-1:0];
          end else if (bzero_q) begin
            hi_d = a_orig_q;
            lo_d = {W{1'b1}};
          end else begin
            hi_d = rem_c;
            lo_d = quo_c;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign mdu.busy = busy_q;
  assign mdu.done = done_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: arithmetic results, latency, flush, reset
// and MTHI/MTLO interaction.
module tb_muldiv_ctrl;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk = 1'b0;
  logic rst;

  muldiv_if bus();

  muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .mdu (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
  endtask

  // Present an issue for one edge (E0); returns just after E0
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Count remaining busy samples, then check the done cycle; returns in the done cycle
  task automatic wait_done(input string tag, input int exp_busy,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    int early;
    cyc   = 0;
    early = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      if (bus.done === 1'b1) early++;
      cyc++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_busy));
    chk({tag, "_early_done"},  64'(early), 64'd0);
    chk({tag, "_done"},        64'(bus.done), 64'd1);
    chk({tag, "_hi"},          64'(bus.hi), 64'(exp_hi));
    chk({tag, "_lo"},          64'(bus.lo), 64'(exp_lo));
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    launch(op, a, b);
    wait_done(tag, 33, exp_hi, exp_lo);
    tick();
    chk({tag, "_done_fall"}, 64'(bus.done), 64'd0);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    chk({tag, "_no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    // Reset with random inputs
    rst       = 1'b1;
    bus.start = 1'($urandom);
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.flush = 1'($urandom);
    bus.mthi  = 1'($urandom);
    bus.mtlo  = 1'($urandom);
    bus.wdata = $urandom;
    tick();
    tick();
    chk("rst_hi",   64'(bus.hi),   64'd0);
    chk("rst_lo",   64'(bus.lo),   64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    idle_inputs();
    rst = 1'b0;
    tick();

    // Arithmetic, including signed corner cases and divide by zero
    run_op("mult_7_m3",    OP_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max",    OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7_2",     OP_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100_7",   OP_DIVU,  32'd100,        32'd7,         32'd2,         32'd14);
    run_op("div_min_m1",   OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_op("divu_by_zero", OP_DIVU,  32'h1234_5678,  32'd0,         32'h1234_5678, 32'hFFFF_FFFF);

    // Reset at RUN count 10 abandons the operation and clears HI/LO
    launch(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi",   64'(bus.hi),   64'd0);
    chk("midrst_lo",   64'(bus.lo),   64'd0);
    watch_no_done("midrst", 40);
    chk("midrst_hi_after", 64'(bus.hi), 64'd0);
    chk("midrst_lo_after", 64'(bus.lo), 64'd0);

    // Preload HI/LO, then flush at RUN count 5
    bus.mthi  = 1'b1;
    bus.wdata = 32'hAAAA_AAAA;
    tick();
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h5555_5555;
    tick();
    bus.mtlo  = 1'b0;
    chk("mt_hi", 64'(bus.hi), 64'hAAAA_AAAA);
    chk("mt_lo", 64'(bus.lo), 64'h5555_5555);
    launch(OP_MULT, 32'd3, 32'd4);
    repeat (5) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    watch_no_done("flush", 40);
    chk("flush_hi", 64'(bus.hi), 64'hAAAA_AAAA);
    chk("flush_lo", 64'(bus.lo), 64'h5555_5555);

    // Flush together with start in IDLE does not launch
    bus.op    = OP_MULT;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    tick();
    idle_inputs();
    chk("flush_start_busy", 64'(bus.busy), 64'd0);
    watch_no_done("flush_start", 40);
    chk("flush_start_hi", 64'(bus.hi), 64'hAAAA_AAAA);

    // Back-to-back: next issue taken in the done cycle
    launch(OP_MULTU, 32'd5, 32'd6);
    wait_done("b2b_first", 33, 32'd0, 32'd30);
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done("b2b_second", 33, 32'd2, 32'd14);
    tick();

    // MTHI during RUN is ignored
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (3) tick();
    bus.mthi  = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    tick();
    bus.mthi  = 1'b0;
    chk("mthi_run_hi", 64'(bus.hi), 64'd2);
    wait_done("mthi_run", 29, 32'd2, 32'd14);
    tick();

    // MTHI with start: write lands, then FIX overwrites it
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0BAD_F00D;
    launch(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    bus.mthi  = 1'b0;
    chk("mthi_start_hi_e0", 64'(bus.hi), 64'h0BAD_F00D);
    repeat (20) tick();
    chk("mthi_start_hi_mid", 64'(bus.hi), 64'h0BAD_F00D);
    wait_done("mthi_start", 13, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
